// File: rtl/prog_mem_pkg.sv
// Shared types and default widths for the program memory, fetch stage and loader.
package prog_mem_pkg;

  localparam int unsigned PM_DATA_W = 26;
  localparam int unsigned PM_ADDR_W = 4;

  typedef enum logic [0:0] {
    PM_INIT,
    PM_RUN
  } pm_state_e;

endpackage

// File: rtl/prog_mem_if.sv
// Read/write port bundle between the program memory and its fetch/loader clients.
interface prog_mem_if
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = PM_DATA_W,
  parameter int unsigned ADDR_W = PM_ADDR_W
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              addr_err;
  logic              busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, wr_ack, addr_err, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, wr_ack, addr_err, busy
  );

endinterface

// File: rtl/prog_mem_clear.sv
// Post-reset clear sequencer: walks every address once, emitting a zero-write each cycle.
module prog_mem_clear
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = PM_ADDR_W,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // One extra counter bit so DEPTH == 2**ADDR_W terminates without aliasing.
  localparam logic [ADDR_W:0] LastCnt = (ADDR_W + 1)'(DEPTH - 1);

  pm_state_e       state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? PM_INIT : PM_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      PM_INIT: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = PM_RUN;
      end
      PM_RUN: ;
      default: state_d = PM_RUN;
    endcase
  end

  assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/prog_mem.sv
// Program memory: registered read with valid strobe, acked write, optional
// read-during-write bypass and a zeroing pass after reset.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W         = PM_DATA_W,
  parameter int unsigned ADDR_W         = PM_ADDR_W,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned BYPASS         = 1
) (
  input logic      clk,
  input logic      reset,
  prog_mem_if.slave bus
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  prog_mem_clear #(
    .ADDR_W        (ADDR_W),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  logic              rd_oor, wr_oor, rd_req, wr_ok, err_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, wr_ack_q, addr_err_q;

  always_comb begin
    rd_oor = {1'b0, bus.rd_addr} >= DepthW;
    wr_oor = {1'b0, bus.wr_addr} >= DepthW;
    rd_req = !busy && bus.rd_en;
    wr_ok  = !busy && bus.wr_en && !wr_oor;
    err_d  = !busy && ((bus.rd_en && rd_oor) || (bus.wr_en && wr_oor));

    // Clear pass owns the write port while busy; nothing commits on a reset cycle.
    mem_we    = !reset && (clr_we || wr_ok);
    mem_waddr = clr_we ? clr_addr : bus.wr_addr;
    mem_wdata = clr_we ? '0 : bus.wr_data;

    rd_data_d = rd_data_q;
    if (rd_req) begin
      if (rd_oor) begin
        rd_data_d = '0;
      end else if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr)) begin
        rd_data_d = bus.wr_data;
      end else begin
        rd_data_d = mem[bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_req;
      wr_ack_q   <= wr_ok;
      addr_err_q <= err_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.addr_err = addr_err_q;
  assign bus.busy     = busy;

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised instruction/program memory for the CPU core, next generation of `instr_mem`. It provides:
- a synchronous write port with acknowledge;
- a registered read port with a valid strobe;
- a configurable read-during-write bypass;
- a post-reset clear sequence that zeroes every word before the port accepts traffic.

It sits between the program counter/fetch stage (read side) and the program loader (write side).

## Interface
- `DATA_W`, 26, instruction word width in bits.
- `ADDR_W`, 4, address width in bits.
- `DEPTH`, 16, number of words. Must satisfy 1 ≤ `DEPTH` ≤ 2^`ADDR_W`.
- `CLEAR_ON_RESET`, 1, when 1, the block zeroes the whole array after reset.
- `BYPASS`, 1, when 1, a same-address, same-cycle read returns the new write data.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  read request.
- `rd_addr`  in  `ADDR_W`  read address.
- `rd_data`  out  `DATA_W`  registered read data.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid.
- `wr_en`  in  1  write request.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `DATA_W`  write data.
- `wr_ack`  out  1  one-cycle pulse; the write was committed.
- `addr_err`  out  1  one-cycle pulse; an accepted request had an address ≥ `DEPTH`.
- `busy`  out  1  high while clearing; all requests are ignored while high.

## Operation
- FSM states:
  - `INIT` clears the array.
  - `RUN` serves requests.
- Reset behaviour:
  - If `CLEAR_ON_RESET`=1: go to `INIT` and set the clear counter to 0.
  - Otherwise: go to `RUN`. Array contents are undefined.
- `INIT`:
  - Each cycle, write 0 to `mem[cnt]` and increment `cnt`.
  - On the cycle that writes `cnt`=`DEPTH`-1, transition to `RUN`.
  - `busy`=1 throughout.
  - `rd_en` and `wr_en` are ignored: no `rd_valid`, no `wr_ack`, no `addr_err`.
- `RUN`, write:
  - `wr_en` with `wr_addr` < `DEPTH` → `mem[wr_addr]` is updated at the edge, and `wr_ack` pulses the next cycle.
  - `wr_en` with `wr_addr` ≥ `DEPTH` → the write is dropped, `wr_ack` stays 0, and `addr_err` pulses the next cycle.
- `RUN`, read:
  - `rd_en` → `rd_data`/`rd_valid` are presented the next cycle.
  - If `rd_addr` ≥ `DEPTH`: `rd_data`=0, `rd_valid`=1, and `addr_err`=1.
  - `rd_data` holds its last value when no read is in flight.
- Read and write in the same cycle, same valid address:
  - `BYPASS`=1 → `rd_data` = `wr_data`.
  - `BYPASS`=0 → `rd_data` = the old contents.
  - The write commits in both cases.
- Read and write in the same cycle, different addresses: fully independent; both complete.
- Both requests out of range in the same cycle: a single `addr_err` pulse.

## Timing
- Reset values, the cycle after `reset`:
  - `rd_data`=0, `rd_valid`=0, `wr_ack`=0, `addr_err`=0.
  - `busy`=`CLEAR_ON_RESET`.
- Clear duration: `busy` is high for exactly `DEPTH` cycles after reset deasserts. The first request is accepted on the cycle `busy` reads 0.
- Read latency: 1 cycle from `rd_en` to `rd_valid`. Back-to-back reads deliver one word per cycle.
- Write acknowledge latency: 1 cycle. A read issued the cycle after a write to the same address returns the new data in both `BYPASS` modes.
- Reset asserted mid-`INIT`: the counter restarts at 0 and the full `DEPTH`-cycle clear repeats.
- Reset asserted in `RUN`: in-flight `rd_valid`/`wr_ack` pulses are suppressed. A write on the reset cycle is not committed.
- Counter width is `ADDR_W`+1, so `DEPTH`=2^`ADDR_W` terminates without wrap aliasing.

## Structure
- Shared package `prog_mem_pkg`:
  - state enum `PM_INIT`, `PM_RUN`;
  - default width constants `PM_DATA_W`=26 and `PM_ADDR_W`=4, shared with the fetch stage and the loader.
- Sub-module `prog_mem_clear`, the `INIT` counter/FSM. It outputs:
  - `busy`;
  - `clr_we`;
  - `clr_addr`.
- The top-level block muxes the clear write into the array write port.
- The array is a plain `reg` vector, inferable as distributed RAM.

## Test plan
- Clear sequence: default parameters; pre-fill via hierarchy with 26'h2AAAAAA; assert `reset` for 2 cycles. Required: `busy` high for exactly 16 cycles; afterwards, reads of addresses 0–15 all return 0 with `rd_valid` each cycle.
- Write then read: write 26'h1555555 to address 3. Required: `wr_ack` the next cycle; `rd_en` to address 3 the following cycle returns 26'h1555555 after 1 cycle.
- Same-cycle collision on address 5 (old contents 26'h0000001), write 26'h3FFFFFF:
  - `BYPASS`=1 → `rd_data`=26'h3FFFFFF.
  - `BYPASS`=0 → `rd_data`=26'h0000001, and a subsequent read returns 26'h3FFFFFF.
- Out of range: `DEPTH`=12.
  - Write to address 13 → no `wr_ack`; `addr_err` pulse.
  - Read of address 14 → `rd_data`=0 with `rd_valid` and `addr_err`.
  - Address 11 is unaffected.
- Reset mid-`INIT`: pulse `reset` at clear cycle 7. Required: `busy` stays high for a further 16 cycles, and requests issued while `busy` produce no responses.
- Streaming: write addresses 0–15 with data = address × 26'h0111111, back to back. Then read 0–15 back to back. Required: 16 consecutive `wr_ack` cycles, then 16 consecutive `rd_valid` cycles with matching data.
